// File: rtl/stoch_pkg.sv
// Shared types and constants for the stochastic adder and its number generators.
package stoch_pkg;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   localparam int unsigned SEL_RR   = 0;
   localparam int unsigned SEL_LFSR = 1;

   // Right-shift Galois feedback masks giving maximal-length sequences.
   // Unlisted widths fall back to the 16-bit mask, which is not maximal for them.
   function automatic logic [31:0] lfsr_mask(input int unsigned width);
      logic [31:0] m;
      case (width)
         4:       m = 32'h0000_000C;
         8:       m = 32'h0000_00B8;
         16:      m = 32'h0000_B400;
         24:      m = 32'h00E1_0000;
         32:      m = 32'h8020_0003;
         default: m = 32'h0000_B400;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/stoch_lfsr.sv
// Galois LFSR with seed reload and step enable; shared by the stochastic number generators.
module stoch_lfsr
   import stoch_pkg::*;
#(
   parameter int unsigned      Width = 16,
   parameter logic [Width-1:0] Seed  = Width'(16'hACE1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic             en_i,
   output logic [Width-1:0] state_o
);

   localparam logic [Width-1:0] Mask = Width'(lfsr_mask(Width));

   logic [Width-1:0] lfsr_q, lfsr_d, step;

   always_comb begin
      step   = (lfsr_q >> 1) ^ (lfsr_q[0] ? Mask : '0);
      lfsr_d = lfsr_q;
      if (load_i) begin
         lfsr_d = Seed;
      end else if (en_i) begin
         lfsr_d = step;
      end
      // The all-zero state is a lock-up point; force recovery to the seed.
      if (lfsr_d == '0) begin
         lfsr_d = Seed;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lfsr_q <= Seed;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign state_o = lfsr_q;

endmodule

// File: rtl/stochastic_nary_adder.sv
// N-input scaled stochastic adder: forwards one input bit per accepted cycle, counts output ones.
// Optional: define STOCH_NARY_ADDER_SEL_OUT_EN to expose the registered channel index on sel_idx.
module stochastic_nary_adder
   import stoch_pkg::*;
#(
   parameter int unsigned       N_INPUTS  = 4,
   parameter int unsigned       SEL_MODE  = SEL_RR,
   parameter int unsigned       LEN_W     = 16,
   parameter int unsigned       LFSR_W    = 16,
   parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_W'(16'hACE1)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [LEN_W-1:0]            stream_len,
   input  logic                        in_valid,
   input  logic [N_INPUTS-1:0]         in_bits,
   output logic                        busy,
   output logic                        out_bit,
   output logic                        out_valid,
   output logic                        done,
`ifdef STOCH_NARY_ADDER_SEL_OUT_EN
   output logic [$clog2(N_INPUTS)-1:0] sel_idx,
`endif
   output logic [LEN_W-1:0]            ones_count
);

   localparam int unsigned SelW = $clog2(N_INPUTS);

   state_e           state_q, state_d;
   logic [LEN_W-1:0] remaining_q, remaining_d;
   logic [LEN_W-1:0] acc_q, acc_d;
   logic [LEN_W-1:0] ones_q, ones_d;
   logic             out_bit_q, out_bit_d;
   logic             out_valid_q, out_valid_d;

   logic [SelW-1:0]  cur_sel;
   logic             cur_bit;
   logic             accept;
   logic             start_ok;

   assign start_ok = (state_q == StIdle) && start;
   assign accept   = (state_q == StRun) && in_valid;
   assign cur_bit  = in_bits[cur_sel];

   if (SEL_MODE == SEL_LFSR) begin : g_lfsr
      logic [LFSR_W-1:0] lfsr_state;
      logic              unused_lfsr_hi;

      stoch_lfsr #(
         .Width (LFSR_W),
         .Seed  (LFSR_SEED)
      ) u_lfsr (
         .clk_i   (clk),
         .rst_ni  (rst),
         .load_i  (start_ok),
         .en_i    (accept),
         .state_o (lfsr_state)
      );

      assign cur_sel        = lfsr_state[SelW-1:0];
      assign unused_lfsr_hi = ^lfsr_state[LFSR_W-1:SelW];
   end else begin : g_rr
      localparam logic [SelW-1:0] SelLast = SelW'(N_INPUTS - 1);

      logic [SelW-1:0] sel_q, sel_d;

      always_comb begin
         sel_d = sel_q;
         if (start_ok) begin
            sel_d = '0;
         end else if (accept) begin
            sel_d = (sel_q == SelLast) ? '0 : sel_q + SelW'(1);
         end
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            sel_q <= '0;
         end else begin
            sel_q <= sel_d;
         end
      end

      assign cur_sel = sel_q;
   end

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      acc_d       = acc_q;
      ones_d      = ones_q;
      out_bit_d   = out_bit_q;
      out_valid_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               remaining_d = stream_len;
               acc_d       = '0;
               if (stream_len == '0) begin
                  ones_d  = '0;
                  state_d = StDone;
               end else begin
                  state_d = StRun;
               end
            end
         end
         StRun: begin
            if (in_valid) begin
               out_bit_d   = cur_bit;
               out_valid_d = 1'b1;
               acc_d       = acc_q + LEN_W'(cur_bit);
               remaining_d = remaining_q - LEN_W'(1);
               // Publish the count on the same edge that enters DONE.
               if (remaining_q == LEN_W'(1)) begin
                  ones_d  = acc_d;
                  state_d = StDone;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         remaining_q <= '0;
         acc_q       <= '0;
         ones_q      <= '0;
         out_bit_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         acc_q       <= acc_d;
         ones_q      <= ones_d;
         out_bit_q   <= out_bit_d;
         out_valid_q <= out_valid_d;
      end
   end

`ifdef STOCH_NARY_ADDER_SEL_OUT_EN
   logic [SelW-1:0] sel_idx_q, sel_idx_d;

   assign sel_idx_d = accept ? cur_sel : sel_idx_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sel_idx_q <= '0;
      end else begin
         sel_idx_q <= sel_idx_d;
      end
   end

   assign sel_idx = sel_idx_q;
`endif

   assign busy       = (state_q == StRun);
   assign done       = (state_q == StDone);
   assign out_bit    = out_bit_q;
   assign out_valid  = out_valid_q;
   assign ones_count = ones_q;

endmodule

// File: tb/tb_stochastic_nary_adder.sv
// Bench for stochastic_nary_adder: round-robin and LFSR instances share stimulus, a stream-level
// model predicts every output each cycle, and directed runs pin hand-computed results.
module tb_stochastic_nary_adder;

   localparam int unsigned N  = 4;
   localparam int unsigned LW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          start = 1'b0;
   logic [LW-1:0] stream_len = '0;
   logic          in_valid = 1'b0;
   logic [N-1:0]  in_bits = '0;

   logic [1:0]    busy, out_bit, out_valid, done;
   logic [LW-1:0] ones_c [2];
`ifdef STOCH_NARY_ADDER_SEL_OUT_EN
   logic [1:0]    sel_idx [2];
`endif

   int errs   = 0;
   int checks = 0;

   always #5 clk = ~clk;

   stochastic_nary_adder #(
      .N_INPUTS (N), .SEL_MODE (0), .LEN_W (LW), .LFSR_W (16), .LFSR_SEED (16'hACE1)
   ) u_rr (
      .clk (clk), .rst (rst), .start (start), .stream_len (stream_len),
      .in_valid (in_valid), .in_bits (in_bits), .busy (busy[0]), .out_bit (out_bit[0]),
      .out_valid (out_valid[0]), .done (done[0]),
`ifdef STOCH_NARY_ADDER_SEL_OUT_EN
      .sel_idx (sel_idx[0]),
`endif
      .ones_count (ones_c[0])
   );

   stochastic_nary_adder #(
      .N_INPUTS (N), .SEL_MODE (1), .LEN_W (LW), .LFSR_W (16), .LFSR_SEED (16'hACE1)
   ) u_lf (
      .clk (clk), .rst (rst), .start (start), .stream_len (stream_len),
      .in_valid (in_valid), .in_bits (in_bits), .busy (busy[1]), .out_bit (out_bit[1]),
      .out_valid (out_valid[1]), .done (done[1]),
`ifdef STOCH_NARY_ADDER_SEL_OUT_EN
      .sel_idx (sel_idx[1]),
`endif
      .ones_count (ones_c[1])
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         if (errs <= 40) $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Stream-level model: phase 0 idle, 1 streaming, 2 done-cycle. Channel of the j-th accepted
   // bit is j mod N for round-robin, or the low bits of the seed advanced j times for LFSR.
   int lfsr_sel [4096];
   int m_phase [2];
   int m_rem [2];
   int m_j [2];
   int m_acc [2];
   int m_cnt [2];
   int m_sel [2];
   bit m_ov [2];
   bit m_ob [2];

   function automatic int pick(input int d, input int j);
      return (d == 0) ? (j % N) : lfsr_sel[j % 4096];
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int d = 0; d < 2; d++) begin
            m_phase[d] = 0; m_rem[d] = 0; m_j[d] = 0; m_acc[d] = 0;
            m_cnt[d] = 0; m_sel[d] = 0; m_ov[d] = 0; m_ob[d] = 0;
         end
      end else begin
         for (int d = 0; d < 2; d++) begin
            bit nov;
            int s;
            nov = 1'b0;
            case (m_phase[d])
               0: if (start) begin
                  m_rem[d] = int'(stream_len);
                  m_acc[d] = 0;
                  m_j[d]   = 0;
                  if (stream_len == 0) begin
                     m_phase[d] = 2;
                     m_cnt[d]   = 0;
                  end else begin
                     m_phase[d] = 1;
                  end
               end
               1: if (in_valid) begin
                  s        = pick(d, m_j[d]);
                  m_ob[d]  = in_bits[s];
                  m_sel[d] = s;
                  nov      = 1'b1;
                  m_acc[d] += int'(in_bits[s]);
                  m_j[d]++;
                  m_rem[d]--;
                  if (m_rem[d] == 0) begin
                     m_phase[d] = 2;
                     m_cnt[d]   = m_acc[d];
                  end
               end
               default: m_phase[d] = 0;
            endcase
            m_ov[d] = nov;
         end
      end
   end

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         check($sformatf("busy[%0d]", d), busy[d], m_phase[d] == 1);
         check($sformatf("done[%0d]", d), done[d], m_phase[d] == 2);
         check($sformatf("out_valid[%0d]", d), out_valid[d], m_ov[d]);
         check($sformatf("ones_count[%0d]", d), ones_c[d], m_cnt[d]);
         if (m_ov[d]) begin
            check($sformatf("out_bit[%0d]", d), out_bit[d], m_ob[d]);
`ifdef STOCH_NARY_ADDER_SEL_OUT_EN
            check($sformatf("sel_idx[%0d]", d), sel_idx[d], m_sel[d]);
`endif
         end
      end
   end

   bit       pv [$];
   logic [3:0] pb [$];
   int       restart_at = 0;
   bit       cap_rr [$];
   bit       cap_lf [$];

   function automatic logic [31:0] pack_q(input bit q [$]);
      logic [31:0] v;
      v = '0;
      foreach (q[i]) v = (v << 1) | 32'(q[i]);
      return v;
   endfunction

   // Pulses start, then drives the valid/bit patterns cyclically until done (bounded by budget).
   task automatic run_stream(input int len, input int budget, output int cycles);
      cap_rr.delete();
      cap_lf.delete();
      cycles = -1;
      @(posedge clk); #1;
      start      = 1'b1;
      stream_len = LW'(len);
      in_valid   = 1'b0;
      for (int k = 1; k <= budget; k++) begin
         @(posedge clk); #1;
         start    = (k == restart_at);
         in_valid = pv[(k - 1) % pv.size()];
         in_bits  = pb[(k - 1) % pb.size()];
         @(negedge clk);
         if (out_valid[0]) cap_rr.push_back(out_bit[0]);
         if (out_valid[1]) cap_lf.push_back(out_bit[1]);
         if (done[0]) begin
            cycles = k;
            break;
         end
      end
      @(posedge clk); #1;
      start    = 1'b0;
      in_valid = 1'b0;
   endtask

   initial begin
      int cyc;
      int s;
      int first_ones;
      int diff;
      bit seq1 [$];

      s = 16'hACE1;
      for (int j = 0; j < 4096; j++) begin
         lfsr_sel[j] = s & 3;
         s = (s >> 1) ^ (((s & 1) != 0) ? 16'hB400 : 0);
      end

      rst = 1'b1;
      #2 rst = 1'b0;
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check("reset_busy", busy[d], 0);
         check("reset_out_valid", out_valid[d], 0);
         check("reset_out_bit", out_bit[d], 0);
         check("reset_done", done[d], 0);
         check("reset_ones", ones_c[d], 0);
`ifdef STOCH_NARY_ADDER_SEL_OUT_EN
         check("reset_sel_idx", sel_idx[d], 0);
`endif
      end
      @(posedge clk); #1 rst = 1'b1;

      // Round-robin on 0011: channels 0,1,2,3 give 1,1,0,0 repeating.
      pv = '{1'b1};
      pb = '{4'b0011};
      run_stream(8, 20, cyc);
      check("rr8_done_cycles", cyc, 9);
      check("rr8_ones", ones_c[0], 4);
      check("rr8_len", cap_rr.size(), 8);
      check("rr8_seq", pack_q(cap_rr), 32'b1100_1100);

      pb = '{4'b1111};
      run_stream(0, 10, cyc);
      check("len0_done_cycles", cyc, 1);
      check("len0_ones_rr", ones_c[0], 0);
      check("len0_ones_lf", ones_c[1], 0);
      check("len0_no_valid", cap_rr.size() + cap_lf.size(), 0);

      // Gaps carry 1111 so a select that advanced on them would change the sequence.
      pv = '{1'b1, 1'b0};
      pb = '{4'b0001, 4'b1111, 4'b0001, 4'b1111, 4'b0100, 4'b1111, 4'b0100, 4'b1111};
      run_stream(4, 20, cyc);
      check("gap_done_cycles", cyc, 8);
      check("gap_ones", ones_c[0], 2);
      check("gap_seq", pack_q(cap_rr), 32'b1010);

      pv = '{1'b1};
      pb = '{4'b0001};
      run_stream(4096, 4200, cyc);
      check("lfsr_done_cycles", cyc, 4097);
      check("rr4096_ones_exact", ones_c[0], 1024);
      check("lfsr_ones_band", (ones_c[1] >= 960) && (ones_c[1] <= 1088), 1);
      first_ones = int'(ones_c[1]);
      seq1 = cap_lf;
      run_stream(4096, 4200, cyc);
      check("lfsr_repeat_ones", ones_c[1], first_ones);
      diff = (cap_lf.size() == seq1.size()) ? 0 : 1;
      foreach (seq1[i]) if (i < cap_lf.size() && cap_lf[i] != seq1[i]) diff++;
      check("lfsr_repeat_seq", diff, 0);

      // Abort mid-stream: outputs drop without waiting for a clock edge.
      @(posedge clk); #1;
      start      = 1'b1;
      stream_len = 16;
      in_valid   = 1'b1;
      in_bits    = 4'b1111;
      @(posedge clk); #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check("abort_busy", busy, 2'b00);
      check("abort_out_valid", out_valid, 2'b00);
      repeat (2) @(negedge clk);
      check("abort_no_done", done, 2'b00);
      @(posedge clk); #1 rst = 1'b1;
      in_valid = 1'b0;
      pv = '{1'b1};
      pb = '{4'b1111};
      run_stream(16, 30, cyc);
      check("post_abort_cycles", cyc, 17);
      check("post_abort_ones_rr", ones_c[0], 16);
      check("post_abort_ones_lf", ones_c[1], 16);

      pb = '{4'b0011};
      restart_at = 3;
      run_stream(8, 20, cyc);
      check("restart_run_cycles", cyc, 9);
      check("restart_run_ones", ones_c[0], 4);
      check("restart_run_seq", pack_q(cap_rr), 32'b1100_1100);
      restart_at = 9;
      run_stream(8, 20, cyc);
      check("restart_done_cycles", cyc, 9);
      check("restart_done_ones", ones_c[0], 4);
      @(negedge clk);
      check("restart_done_idle", busy, 2'b00);
      restart_at = 0;

      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
